// File: rtl/ex3_pkg.sv
// Shared excess-3 definitions: FSM state encoding, code offset and legal code range.
package ex3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int NIB_W = 4;

    localparam logic [NIB_W-1:0] EX3_OFFSET = 4'd3;
    localparam logic [NIB_W-1:0] EX3_MIN    = 4'd3;
    localparam logic [NIB_W-1:0] EX3_MAX    = 4'd12;

endpackage

// File: rtl/ex3_digit_dec.sv
// Combinational single-digit excess-3 decoder; illegal codes yield digit 0 with the flag set.
module ex3_digit_dec
    import ex3_pkg::*;
(
    input  logic [3:0] nib,
    output logic [3:0] digit,
    output logic       illegal
);

    always_comb begin
        illegal = (nib < EX3_MIN) || (nib > EX3_MAX);
        digit   = illegal ? 4'd0 : (nib - EX3_OFFSET);
    end

endmodule

// File: rtl/ex3_to_bcd_dec.sv
// Sequential multi-digit excess-3 to BCD decoder, one digit per clock, MSD first.
// Optional binary output bin_out is enabled by defining EX3_DEC_BIN_EN.
module ex3_to_bcd_dec
    import ex3_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   ex3_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     err_mask,
    output logic                  err,
    output logic                  out_valid,
`ifdef EX3_DEC_BIN_EN
    output logic [BIN_W-1:0]      bin_out,
`endif
    input  logic                  out_ready
);

    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int WORD_W = NIB_W * DIGITS;

    // Reject configurations whose binary width cannot hold the largest decimal word.
    if (DIGITS < 1 || DIGITS > 8 ||
        (64'd1 << BIN_W) <= 64'(10**DIGITS - 1)) begin : g_cfg_err
        $error("ex3_to_bcd_dec: unsupported DIGITS/BIN_W combination");
    end

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]   err_mask_q, err_mask_d;

    logic [NIB_W-1:0]    nib_cur;
    logic [NIB_W-1:0]    dig_cur;
    logic                ill_cur;

    assign nib_cur = word_q[idx_q*NIB_W +: NIB_W];

    ex3_digit_dec u_digit_dec (
        .nib     (nib_cur),
        .digit   (dig_cur),
        .illegal (ill_cur)
    );

`ifdef EX3_DEC_BIN_EN
    logic [BIN_W-1:0]    acc_q, acc_d;
`endif

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        bcd_d      = bcd_q;
        err_mask_d = err_mask_q;
`ifdef EX3_DEC_BIN_EN
        acc_d      = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d     = ex3_in;
                    bcd_d      = '0;
                    err_mask_d = '0;
                    idx_d      = IDX_W'(DIGITS - 1);
`ifdef EX3_DEC_BIN_EN
                    acc_d      = '0;
`endif
                    state_d    = CONV;
                end
            end
            CONV: begin
                bcd_d[idx_q*NIB_W +: NIB_W] = dig_cur;
                err_mask_d[idx_q]           = ill_cur;
`ifdef EX3_DEC_BIN_EN
                // Horner step, MSD first; the register width performs the truncation.
                acc_d = acc_q * BIN_W'(10) + BIN_W'(dig_cur);
`endif
                if (idx_q == '0) begin
                    state_d = HOLD;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_q     <= '0;
            idx_q      <= '0;
            bcd_q      <= '0;
            err_mask_q <= '0;
`ifdef EX3_DEC_BIN_EN
            acc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            bcd_q      <= bcd_d;
            err_mask_q <= err_mask_d;
`ifdef EX3_DEC_BIN_EN
            acc_q      <= acc_d;
`endif
        end
    end

    // Handshake flags come straight from the state register, so reset clears them immediately.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign bcd_out   = bcd_q;
    assign err_mask  = err_mask_q;
    assign err       = |err_mask_q;
`ifdef EX3_DEC_BIN_EN
    assign bin_out   = acc_q;
`endif

endmodule

// File: tb/tb_ex3_to_bcd_dec.sv
// Scoreboard bench for ex3_to_bcd_dec: driver pushes expected results, monitor pops on output handshake.
module tb_ex3_to_bcd_dec;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
    localparam int WW     = 4 * DIGITS;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [WW-1:0]     ex3_in;
    logic              in_valid;
    logic              in_ready;
    logic [WW-1:0]     bcd_out;
    logic [DIGITS-1:0] err_mask;
    logic              err;
    logic              out_valid;
    logic              out_ready;
`ifdef EX3_DEC_BIN_EN
    logic [BIN_W-1:0]  bin_out;
`endif

    ex3_to_bcd_dec #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex3_in    (ex3_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_out   (bcd_out),
        .err_mask  (err_mask),
        .err       (err),
        .out_valid (out_valid),
`ifdef EX3_DEC_BIN_EN
        .bin_out   (bin_out),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0]     bcd;
        logic [DIGITS-1:0] mask;
        longint            bin;
        longint            acc_cyc;
    } exp_t;

    exp_t   sb[$];
    longint cyc = 0;
    int     n_chk = 0;
    int     n_fail = 0;
    bit     rand_rdy = 0;
    bit     prev_v = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: each nibble independently, value = sum(digit_i * 10^i) mod 2^BIN_W.
    function automatic exp_t model(input logic [WW-1:0] w);
        exp_t   e;
        longint scale = 1;
        int     v, d;
        e.bcd  = '0;
        e.mask = '0;
        e.bin  = 0;
        for (int i = 0; i < DIGITS; i++) begin
            v = int'(w[4*i +: 4]);
            if (v >= 3 && v <= 12) d = v - 3;
            else begin
                d = 0;
                e.mask[i] = 1'b1;
            end
            e.bcd[4*i +: 4] = 4'(d);
            e.bin = e.bin + longint'(d) * scale;
            scale = scale * 10;
        end
        e.bin = e.bin % (longint'(1) << BIN_W);
        e.acc_cyc = 0;
        return e;
    endfunction

    // Drive a word (after posedge), wait for in_ready, push expected at the accepting edge.
    task automatic send(input logic [WW-1:0] w, input logic [WW-1:0] ebcd,
                        input logic [DIGITS-1:0] emask, input longint ebin);
        exp_t e;
        int   tries = 0;
        ex3_in   = w;
        in_valid = 1'b1;
        while (!in_ready && tries < 200) begin
            @(posedge clk); #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            tries++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
        end else begin
            e.bcd = ebcd;
            e.mask = emask;
            e.bin = ebin;
            e.acc_cyc = cyc + 1;
            sb.push_back(e);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        ex3_in   = WW'($urandom);
    endtask

    task automatic send_model(input logic [WW-1:0] w);
        exp_t e;
        e = model(w);
        send(w, e.bcd, e.mask, e.bin);
    endtask

    task automatic wait_out();
        int t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
    endtask

    task automatic drain();
        int t = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || !in_ready) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_done", longint'(sb.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, longint'(out_valid), 0);
        check({tag, "_bcd_out"}, longint'(bcd_out), 0);
        check({tag, "_err_mask"}, longint'(err_mask), 0);
        check({tag, "_err"}, longint'(err), 0);
        check({tag, "_in_ready"}, longint'(in_ready), 1);
`ifdef EX3_DEC_BIN_EN
        check({tag, "_bin_out"}, longint'(bin_out), 0);
`endif
    endtask

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        int v;
        for (int i = 0; i < DIGITS; i++) begin
            if ($urandom_range(0, 9) < 8) v = int'($urandom_range(3, 12));
            else begin
                v = int'($urandom_range(0, 5));
                if (v >= 3) v = v + 10;
            end
            w[4*i +: 4] = 4'(v);
        end
        return w;
    endfunction

    // Monitor: latency on each rising out_valid, full compare on each output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) check("unexpected_output", 1, 0);
                else check("latency", cyc - sb[0].acc_cyc, DIGITS);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                check("bcd_out", longint'(bcd_out), longint'(e.bcd));
                check("err_mask", longint'(err_mask), longint'(e.mask));
                check("err", longint'(err), longint'(|e.mask));
`ifdef EX3_DEC_BIN_EN
                check("bin_out", longint'(bin_out), e.bin);
`endif
            end
            prev_v = out_valid;
        end
    end

    initial begin
        logic [WW-1:0]     snap_bcd;
        logic [DIGITS-1:0] snap_mask;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ex3_in    = '0;

        // Reset with random inputs toggling
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            ex3_in    = WW'($urandom);
            check_reset_outputs("reset");
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        @(posedge clk); #1;

        // Directed words
        send(16'h3456, 16'h0123, 4'b0000, 123);
        drain();
        send(16'hC3B2, 16'h9080, 4'b0001, 9080);
        drain();
        send(16'h3333, 16'h0000, 4'b0000, 0);
        drain();
        send(16'hCCCC, 16'h9999, 4'b0000, 9999);
        drain();
        send(16'h0FDC, 16'h0009, 4'b1110, 9);
        drain();

        // Backpressure in HOLD with a competing input word
        out_ready = 1'b0;
        send(16'h4C58, 16'h1925, 4'b0000, 1925);
        wait_out();
        snap_bcd  = bcd_out;
        snap_mask = err_mask;
        ex3_in    = 16'h7A39;
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", longint'(out_valid), 1);
            check("hold_bcd_stable", longint'(bcd_out), longint'(snap_bcd));
            check("hold_mask_stable", longint'(err_mask), longint'(snap_mask));
            check("hold_in_ready", longint'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_out_valid", longint'(out_valid), 0);
        check("release_in_ready", longint'(in_ready), 1);
        send(16'h7A39, 16'h4706, 4'b0000, 4706);
        drain();

        // Asynchronous reset two cycles into CONV
        send(16'h4567, 16'h1234, 4'b0000, 1234);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_reset_outputs("abort_conv");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(16'h3B3C, 16'h0809, 4'b0000, 809);
        drain();

        // Asynchronous reset while holding a result
        out_ready = 1'b0;
        send(16'h5C33, 16'h2900, 4'b0000, 2900);
        wait_out();
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_reset_outputs("abort_hold");
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Randomized words with random output backpressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send_model(rand_word());
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        rand_rdy = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
